alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit MIPS-style integer ALU for the execute stage.
- Selects operand B from the register file (RD2) or the sign-extended immediate (SignImm), then performs one of 16 operations picked by ALUControl.
- Primary outputs ALUResult, Zero and overflow are purely combinational.
- Also provides a one-cycle registered copy of those outputs and a sticky overflow status flag, for the pipeline register and exception logic.

Parameters:
- None. Data width is fixed at 32; shift amount is 5 bits.

Ports:
- clk  in  1  Clock; all registered outputs update on the rising edge.
- rst  in  1  Reset, synchronous, active-high.
- ALUSrc  in  1  0: SrcB = RD2. 1: SrcB = SignImm.
- SrcA  in  32  Operand A.
- RD2  in  32  Register operand. Always the data operand for shifts.
- SignImm  in  32  Sign-extended immediate.
- sa  in  5  Shift amount for SLL/SRL/SRA.
- ALUControl  in  4  Operation select.
- ALUResult  out  32  Combinational result.
- Zero  out  1  Combinational; 1 when ALUResult == 0.
- overflow  out  1  Combinational signed-overflow flag.
- ALUResult_q  out  32  ALUResult registered.
- Zero_q  out  1  Zero registered.
- overflow_q  out  1  overflow registered.
- ovf_sticky  out  1  Set by any registered overflow; cleared only by rst.

Behaviour:
- SrcB = ALUSrc ? SignImm : RD2.
  - The unselected operand must not affect any output, including when it is X.
- Operations by ALUControl (R = ALUResult):
  - 0000 ADD: R = SrcA + SrcB, mod 2^32. overflow = (A[31]==B[31]) && (R[31]!=A[31]).
  - 0001 ADDU: R = SrcA + SrcB, wraps. overflow = 0.
  - 0010 SUB: R = SrcA - SrcB. overflow = (A[31]!=B[31]) && (R[31]!=A[31]).
  - 0011 SUBU: R = SrcA - SrcB, wraps. overflow = 0.
  - 0100 AND: R = SrcA & SrcB.
  - 0101 OR: R = SrcA | SrcB.
  - 0110 SLL: R = RD2 << sa, zero fill. SrcA and ALUSrc are ignored.
  - 0111 SRL: R = RD2 >> sa, logical (zero fill).
  - 1000 SLT: R = 1 if signed SrcA < signed SrcB, else 0.
    - Must be correct when SrcA - SrcB overflows: if the signs differ, the result is A[31]; otherwise it is diff[31].
  - 1001 BEQ and 1010 BNE: R = SrcA - SrcB. overflow = 0. Branch logic uses Zero.
  - 1011 XOR: R = SrcA ^ SrcB.
  - 1100 NOR: R = ~(SrcA | SrcB).
  - 1101 SLTU: R = 1 if unsigned SrcA < unsigned SrcB, else 0.
  - 1110 SRA: R = RD2 >>> sa, sign fill.
  - 1111 LUI: R = {SrcB[15:0], 16'h0000}.
- overflow is 0 for every code except 0000 and 0010.
- Zero = (R == 0) for all codes.
- Combinational outputs carry no clock latency. They settle within the same cycle as their inputs.
- Registered path, on each rising clk edge:
  - If rst = 1: ALUResult_q = 0, Zero_q = 1, overflow_q = 0, ovf_sticky = 0.
  - Otherwise: ALUResult_q = ALUResult, Zero_q = Zero, overflow_q = overflow, and ovf_sticky = ovf_sticky | overflow.
- Latency from inputs to the *_q outputs is 1 cycle.
- rst takes priority over a simultaneous overflow in the same cycle: ovf_sticky ends at 0.
- Shift boundaries:
  - sa = 0 passes RD2 unchanged.
  - sa = 31 on SRL with RD2 = 0x80000000 gives 0x00000001.

Test Plan:
- ADD 10 + 20 (ALUSrc=0) -> R = 30, Zero = 0, overflow = 0. ADDI path: SrcA = 10, SignImm = 5, ALUSrc = 1, RD2 = X -> R = 15.
- ADDU 0xFFFFFFFF + 1 -> R = 0, Zero = 1, overflow = 0. SUBU 5 - 20 -> R = 0xFFFFFFF1, overflow = 0.
- ADD 0x7FFFFFFF + 1 -> R = 0x80000000, overflow = 1. SUB 0x80000000 - 1 -> R = 0x7FFFFFFF, overflow = 1. SUB 20 - 5 -> R = 15, overflow = 0.
- AND and OR of 0xF0F0F0F0 with 0x0FF00FF0 -> 0x00F000F0 and 0xFFF0FFF0. SLL of 1 by 4 -> 16. SRL of 0x80000000 by 31 -> 1. SRA of 0x80000000 by 4 -> 0xF8000000.
- SLT 3 vs 5 -> 1. SLT 0x80000000 vs 1 -> 1. SLTU 0x80000000 vs 1 -> 0. BEQ 7, 7 -> Zero = 1. BNE 7, 8 -> R = 0xFFFFFFFF, Zero = 0, overflow = 0.
- Registered path:
  - Assert rst for one cycle -> *_q = 0, Zero_q = 1, ovf_sticky = 0.
  - Apply an overflowing ADD for one cycle -> overflow_q = 1 and ovf_sticky = 1 after the edge.
  - Apply a normal ADD -> overflow_q = 0 while ovf_sticky stays 1.
  - Assert rst -> ovf_sticky = 0.

Source files
------------

// File: rtl/alu_if.sv
// Execute-stage ALU bus: operands and control in, result/flags out.
// Both the combinational and the registered copies of the flags are carried here.
interface alu_if;
  logic        ALUSrc;
  logic [31:0] SrcA;
  logic [31:0] RD2;
  logic [31:0] SignImm;
  logic [4:0]  sa;
  logic [3:0]  ALUControl;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        overflow;
  logic [31:0] ALUResult_q;
  logic        Zero_q;
  logic        overflow_q;
  logic        ovf_sticky;

  modport master (
    output ALUSrc, SrcA, RD2, SignImm, sa, ALUControl,
    input  ALUResult, Zero, overflow,
    input  ALUResult_q, Zero_q, overflow_q, ovf_sticky
  );

  modport slave (
    input  ALUSrc, SrcA, RD2, SignImm, sa, ALUControl,
    output ALUResult, Zero, overflow,
    output ALUResult_q, Zero_q, overflow_q, ovf_sticky
  );
endinterface

// File: rtl/alu.sv
// 32-bit MIPS-style ALU with combinational outputs, a one-cycle
// registered copy and a sticky overflow status flag.
module alu (
  input logic  clk,
  input logic  rst,
  alu_if.slave bus
);

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] r;
  logic        ovf;
  logic        zero;

  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic        stk_q, stk_d;

  assign a    = bus.SrcA;
  assign b    = bus.ALUSrc ? bus.SignImm : bus.RD2;
  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    r   = '0;
    ovf = 1'b0;
    case (bus.ALUControl)
      4'b0000: begin
        r   = sum;
        ovf = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      4'b0001: r = sum;
      4'b0010: begin
        r   = diff;
        ovf = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      4'b0011: r = diff;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = bus.RD2 << bus.sa;
      4'b0111: r = bus.RD2 >> bus.sa;
      // Sign compare stays correct when a - b overflows
      4'b1000: r = {31'd0, (a[31] != b[31]) ? a[31] : diff[31]};
      4'b1001: r = diff;
      4'b1010: r = diff;
      4'b1011: r = a ^ b;
      4'b1100: r = ~(a | b);
      4'b1101: r = {31'd0, (a < b)};
      4'b1110: r = $unsigned($signed(bus.RD2) >>> bus.sa);
      4'b1111: r = {b[15:0], 16'h0000};
      default: r = '0;
    endcase
  end

  assign zero          = (r == 32'd0);
  assign bus.ALUResult = r;
  assign bus.Zero      = zero;
  assign bus.overflow  = ovf;

  assign res_d  = r;
  assign zero_d = zero;
  assign ovf_d  = ovf;
  assign stk_d  = stk_q | ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
      stk_q  <= 1'b0;
    end else begin
      res_q  <= res_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      stk_q  <= stk_d;
    end
  end

  assign bus.ALUResult_q = res_q;
  assign bus.Zero_q      = zero_q;
  assign bus.overflow_q  = ovf_q;
  assign bus.ovf_sticky  = stk_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the alu: combinational ops, flags,
// shift boundaries and the registered/sticky path.
module tb_alu;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [3:0]  ctl,
                    input logic [31:0] a,
                    input logic        src,
                    input logic [31:0] rd2,
                    input logic [31:0] imm,
                    input logic [4:0]  s);
    bus.ALUControl = ctl;
    bus.SrcA       = a;
    bus.ALUSrc     = src;
    bus.RD2        = rd2;
    bus.SignImm    = imm;
    bus.sa         = s;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    op(4'b0000, 32'd0, 1'b0, 32'd0, 32'd0, 5'd0);
    @(posedge clk); #1;
    chk("rst_res_q", bus.ALUResult_q, 32'd0);
    chk("rst_zero_q", {31'd0, bus.Zero_q}, 32'd1);
    chk("rst_ovf_q", {31'd0, bus.overflow_q}, 32'd0);
    chk("rst_sticky", {31'd0, bus.ovf_sticky}, 32'd0);
    rst = 1'b0;

    op(4'b0000, 32'd10, 1'b0, 32'd20, 32'hxxxxxxxx, 5'd0);
    chk("add_r", bus.ALUResult, 32'd30);
    chk("add_z", {31'd0, bus.Zero}, 32'd0);
    chk("add_v", {31'd0, bus.overflow}, 32'd0);

    op(4'b0000, 32'd10, 1'b1, 32'hxxxxxxxx, 32'd5, 5'd0);
    chk("addi_r", bus.ALUResult, 32'd15);
    chk("addi_z", {31'd0, bus.Zero}, 32'd0);
    chk("addi_v", {31'd0, bus.overflow}, 32'd0);

    op(4'b0001, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0, 5'd0);
    chk("addu_r", bus.ALUResult, 32'd0);
    chk("addu_z", {31'd0, bus.Zero}, 32'd1);
    chk("addu_v", {31'd0, bus.overflow}, 32'd0);

    op(4'b0011, 32'd5, 1'b0, 32'd20, 32'd0, 5'd0);
    chk("subu_r", bus.ALUResult, 32'hFFFFFFF1);
    chk("subu_v", {31'd0, bus.overflow}, 32'd0);

    op(4'b0000, 32'h7FFFFFFF, 1'b0, 32'd1, 32'd0, 5'd0);
    chk("addovf_r", bus.ALUResult, 32'h80000000);
    chk("addovf_v", {31'd0, bus.overflow}, 32'd1);

    op(4'b0010, 32'h80000000, 1'b0, 32'd1, 32'd0, 5'd0);
    chk("subovf_r", bus.ALUResult, 32'h7FFFFFFF);
    chk("subovf_v", {31'd0, bus.overflow}, 32'd1);

    op(4'b0010, 32'd20, 1'b0, 32'd5, 32'd0, 5'd0);
    chk("sub_r", bus.ALUResult, 32'd15);
    chk("sub_v", {31'd0, bus.overflow}, 32'd0);

    op(4'b0100, 32'hF0F0F0F0, 1'b0, 32'h0FF00FF0, 32'd0, 5'd0);
    chk("and_r", bus.ALUResult, 32'h00F000F0);
    op(4'b0101, 32'hF0F0F0F0, 1'b0, 32'h0FF00FF0, 32'd0, 5'd0);
    chk("or_r", bus.ALUResult, 32'hFFF0FFF0);
    op(4'b1011, 32'hF0F0F0F0, 1'b0, 32'h0FF00FF0, 32'd0, 5'd0);
    chk("xor_r", bus.ALUResult, 32'hFF00FF00);
    op(4'b1100, 32'hF0F0F0F0, 1'b0, 32'h0FF00FF0, 32'd0, 5'd0);
    chk("nor_r", bus.ALUResult, 32'h000F000F);

    op(4'b0110, 32'hxxxxxxxx, 1'bx, 32'd1, 32'd0, 5'd4);
    chk("sll_r", bus.ALUResult, 32'd16);
    op(4'b0110, 32'd0, 1'b0, 32'hA5A5A5A5, 32'd0, 5'd0);
    chk("sll0_r", bus.ALUResult, 32'hA5A5A5A5);
    op(4'b0111, 32'd0, 1'b0, 32'h80000000, 32'd0, 5'd31);
    chk("srl31_r", bus.ALUResult, 32'd1);
    op(4'b1110, 32'd0, 1'b0, 32'h80000000, 32'd0, 5'd4);
    chk("sra_r", bus.ALUResult, 32'hF8000000);
    op(4'b1110, 32'd0, 1'b0, 32'h40000000, 32'd0, 5'd4);
    chk("sra_pos_r", bus.ALUResult, 32'h04000000);

    op(4'b1000, 32'd3, 1'b0, 32'd5, 32'd0, 5'd0);
    chk("slt_r", bus.ALUResult, 32'd1);
    op(4'b1000, 32'h80000000, 1'b0, 32'd1, 32'd0, 5'd0);
    chk("slt_neg_r", bus.ALUResult, 32'd1);
    op(4'b1000, 32'h7FFFFFFF, 1'b0, 32'hFFFFFFFF, 32'd0, 5'd0);
    chk("slt_ovf_r", bus.ALUResult, 32'd0);
    chk("slt_ovf_v", {31'd0, bus.overflow}, 32'd0);
    op(4'b1101, 32'h80000000, 1'b0, 32'd1, 32'd0, 5'd0);
    chk("sltu_r", bus.ALUResult, 32'd0);
    op(4'b1101, 32'd1, 1'b0, 32'h80000000, 32'd0, 5'd0);
    chk("sltu_lt_r", bus.ALUResult, 32'd1);

    op(4'b1001, 32'd7, 1'b0, 32'd7, 32'd0, 5'd0);
    chk("beq_z", {31'd0, bus.Zero}, 32'd1);
    op(4'b1010, 32'd7, 1'b0, 32'd8, 32'd0, 5'd0);
    chk("bne_r", bus.ALUResult, 32'hFFFFFFFF);
    chk("bne_z", {31'd0, bus.Zero}, 32'd0);
    chk("bne_v", {31'd0, bus.overflow}, 32'd0);
    op(4'b1010, 32'h80000000, 1'b0, 32'd1, 32'd0, 5'd0);
    chk("bne_novf_v", {31'd0, bus.overflow}, 32'd0);

    op(4'b1111, 32'hxxxxxxxx, 1'b1, 32'hxxxxxxxx, 32'h00001234, 5'd0);
    chk("lui_r", bus.ALUResult, 32'h12340000);

    rst = 1'b1;
    op(4'b0000, 32'd1, 1'b0, 32'd1, 32'd0, 5'd0);
    @(posedge clk); #1;
    chk("r2_res_q", bus.ALUResult_q, 32'd0);
    chk("r2_zero_q", {31'd0, bus.Zero_q}, 32'd1);
    chk("r2_sticky", {31'd0, bus.ovf_sticky}, 32'd0);
    rst = 1'b0;

    op(4'b0000, 32'h7FFFFFFF, 1'b0, 32'd1, 32'd0, 5'd0);
    chk("q_hold_res", bus.ALUResult_q, 32'd0);
    @(posedge clk); #1;
    chk("q_ovf_res", bus.ALUResult_q, 32'h80000000);
    chk("q_ovf_v", {31'd0, bus.overflow_q}, 32'd1);
    chk("q_ovf_stk", {31'd0, bus.ovf_sticky}, 32'd1);

    op(4'b0000, 32'd10, 1'b0, 32'd20, 32'd0, 5'd0);
    @(posedge clk); #1;
    chk("q_add_res", bus.ALUResult_q, 32'd30);
    chk("q_add_z", {31'd0, bus.Zero_q}, 32'd0);
    chk("q_add_v", {31'd0, bus.overflow_q}, 32'd0);
    chk("q_add_stk", {31'd0, bus.ovf_sticky}, 32'd1);

    op(4'b0001, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0, 5'd0);
    @(posedge clk); #1;
    chk("q_zero_q", {31'd0, bus.Zero_q}, 32'd1);
    chk("q_zero_stk", {31'd0, bus.ovf_sticky}, 32'd1);

    rst = 1'b1;
    op(4'b0000, 32'h7FFFFFFF, 1'b0, 32'd1, 32'd0, 5'd0);
    @(posedge clk); #1;
    chk("rp_stk", {31'd0, bus.ovf_sticky}, 32'd0);
    chk("rp_ovf_q", {31'd0, bus.overflow_q}, 32'd0);
    chk("rp_res_q", bus.ALUResult_q, 32'd0);
    chk("rp_comb_v", {31'd0, bus.overflow}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
